// File: rtl/emu_step_ctrl_pkg.sv
// Shared types for the emulator step controller: host command opcodes,
// FSM state and run mode.
package emu_step_pkg;

    typedef enum logic [1:0] {
        OP_NOP      = 2'd0,
        OP_STEP_N   = 2'd1,
        OP_FREE_RUN = 2'd2,
        OP_RSVD     = 2'd3
    } cmd_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic {
        MODE_STEPN = 1'b0,
        MODE_FREE  = 1'b1
    } mode_t;

endpackage

// File: rtl/emu_step_ctrl_if.sv
// Host-side bundle of the step controller: command handshake, run control,
// dt requests, and the pulse/time outputs, plus FSM debug visibility.
interface emu_step_ctrl_if #(
    parameter int N_REQ      = 4,
    parameter int DT_WIDTH   = 32,
    parameter int CNT_WIDTH  = 24,
    parameter int TIME_WIDTH = 48
);
    import emu_step_pkg::*;

    // Command handshake: a command transfers on a cycle where cmd_valid_i and
    // cmd_ready_o are both high; the host holds op/count stable while valid.
    logic                                cmd_valid_i;
    logic                                cmd_ready_o;
    logic [1:0]                          cmd_op_i;
    logic [CNT_WIDTH-1:0]                cmd_count_i;
    logic                                stop_i;
    logic                                stall_i;
    logic [N_REQ-1:0][DT_WIDTH-1:0]      dt_req_i;
    logic                                clk_val_o;
    logic signed [DT_WIDTH-1:0]          dt_o;
    logic                                busy_o;
    logic                                done_o;
    logic [CNT_WIDTH-1:0]                remaining_o;
    logic [31:0]                         step_count_o;
    logic [TIME_WIDTH-1:0]               emu_time_o;
    state_t                              dbg_state;
    mode_t                               dbg_mode;

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_count_i, stop_i, stall_i, dt_req_i,
        output cmd_ready_o, clk_val_o, dt_o, busy_o, done_o, remaining_o,
               step_count_o, emu_time_o, dbg_state, dbg_mode
    );

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_count_i, stop_i, stall_i, dt_req_i,
        input  cmd_ready_o, clk_val_o, dt_o, busy_o, done_o, remaining_o,
               step_count_o, emu_time_o, dbg_state, dbg_mode
    );

endinterface

// File: rtl/emu_step_ctrl_dt_min_arb.sv
// Combinational timestep arbiter: smallest strictly positive request, never
// larger than DT_MAX; DT_MAX when nobody asks.
module dt_min_arb #(
    parameter int N_REQ    = 4,
    parameter int DT_WIDTH = 32,
    parameter int DT_MAX   = 1000
) (
    input  logic [N_REQ-1:0][DT_WIDTH-1:0] dt_req,
    output logic signed [DT_WIDTH-1:0]     dt_min
);

    localparam logic signed [DT_WIDTH-1:0] DT_CAP  = DT_WIDTH'(DT_MAX);
    localparam logic signed [DT_WIDTH-1:0] DT_ZERO = '0;

    logic signed [DT_WIDTH-1:0] req_s;

    // Seeding with the cap folds the clamp and the no-request default together.
    always_comb begin
        dt_min = DT_CAP;
        req_s  = DT_ZERO;
        for (int i = 0; i < N_REQ; i++) begin
            req_s = $signed(dt_req[i]);
            if ((req_s > DT_ZERO) && (req_s < dt_min)) begin
                dt_min = req_s;
            end
        end
    end

endmodule

// File: rtl/emu_step_ctrl.sv
// Emulator clock-enable sequencer: runs STEP_N / FREE_RUN commands as spaced
// one-cycle pulses, arbitrates dt per pulse and accumulates emulated time.
module emu_step_ctrl
    import emu_step_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DT_WIDTH   = 32,
    parameter int DT_MAX     = 1000,
    parameter int CNT_WIDTH  = 24,
    parameter int TIME_WIDTH = 48,
    parameter int STEP_GAP   = 1
) (
    input  logic           __emu_clk,
    input  logic           __emu_rst_n,
    emu_step_ctrl_if.slave bus
);

    localparam int GAP_W = (STEP_GAP > 0) ? $clog2(STEP_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(STEP_GAP);

    state_t                     state, state_d;
    mode_t                      mode, mode_d;
    logic [GAP_W-1:0]           gap_cnt;
    logic [CNT_WIDTH-1:0]       remaining_d;
    logic                       done_d;
    logic                       idle, accept, eligible, last_step, run_stop;
    cmd_op_t                    op;
    logic signed [DT_WIDTH-1:0] arb_dt;

    dt_min_arb #(
        .N_REQ    (N_REQ),
        .DT_WIDTH (DT_WIDTH),
        .DT_MAX   (DT_MAX)
    ) u_arb (
        .dt_req (bus.dt_req_i),
        .dt_min (arb_dt)
    );

    assign op        = cmd_op_t'(bus.cmd_op_i);
    assign idle      = (state == ST_IDLE);
    assign accept    = bus.cmd_valid_i && idle;
    assign eligible  = (state == ST_RUN) && !bus.stop_i && !bus.stall_i && (gap_cnt == '0);
    assign last_step = eligible && (mode == MODE_STEPN) && (bus.remaining_o == CNT_WIDTH'(1));
    assign run_stop  = (state == ST_RUN) && bus.stop_i;

    assign bus.cmd_ready_o = idle;
    assign bus.busy_o      = (state == ST_RUN);
    assign bus.dbg_state   = state;
    assign bus.dbg_mode    = mode;

    always_ff @(posedge __emu_clk or negedge __emu_rst_n) begin
        if (!__emu_rst_n) begin
            state <= ST_IDLE;
            mode  <= MODE_STEPN;
        end else begin
            state <= state_d;
            mode  <= mode_d;
        end
    end

    // Stop wins over an eligible pulse; the final STEP_N pulse and done_o land together.
    always_comb begin
        state_d     = state;
        mode_d      = mode;
        remaining_d = bus.remaining_o;
        done_d      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (op == OP_STEP_N) begin
                        remaining_d = bus.cmd_count_i;
                        if (bus.cmd_count_i == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                            mode_d  = MODE_STEPN;
                        end
                    end else if (op == OP_FREE_RUN) begin
                        remaining_d = '0;
                        state_d     = ST_RUN;
                        mode_d      = MODE_FREE;
                    end
                end
            end
            ST_RUN: begin
                if (run_stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (eligible) begin
                    if (mode == MODE_STEPN) begin
                        remaining_d = bus.remaining_o - CNT_WIDTH'(1);
                    end
                    if (last_step) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge __emu_clk or negedge __emu_rst_n) begin
        if (!__emu_rst_n) begin
            bus.clk_val_o    <= 1'b0;
            bus.done_o       <= 1'b0;
            bus.remaining_o  <= '0;
            bus.dt_o         <= '0;
            bus.step_count_o <= '0;
            bus.emu_time_o   <= '0;
            gap_cnt          <= '0;
        end else begin
            bus.clk_val_o   <= eligible;
            bus.done_o      <= done_d;
            bus.remaining_o <= remaining_d;
            bus.dt_o        <= arb_dt;
            if (bus.clk_val_o) begin
                bus.step_count_o <= bus.step_count_o + 32'd1;
                bus.emu_time_o   <= bus.emu_time_o + TIME_WIDTH'(bus.dt_o);
            end
            if (eligible) begin
                gap_cnt <= GAP_RELOAD;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

endmodule
